// File: rtl/training_sequencer_if.sv
// Control/status bundle between the training host (master) and the training sequencer (slave).
interface training_sequencer_if #(
   parameter int unsigned ERR_W   = 34,
   parameter int unsigned EPOCH_W = 16
);
   logic               start;
   logic               abort;
   logic [1:0]         mode_sel;
   logic               err_valid;
   logic [ERR_W-1:0]   squared_error;
   logic [ERR_W-1:0]   err_threshold;
   logic [EPOCH_W-1:0] max_epochs;
   logic               adam_signal;
   logic               manhatten_signal;
   logic               busy;
   logic               training_done;
   logic               converged;
   logic               timeout;
   logic [EPOCH_W-1:0] epoch_count;

   modport master (
      output start, abort, mode_sel, err_valid, squared_error, err_threshold, max_epochs,
      input  adam_signal, manhatten_signal, busy, training_done, converged, timeout, epoch_count
   );

   modport slave (
      input  start, abort, mode_sel, err_valid, squared_error, err_threshold, max_epochs,
      output adam_signal, manhatten_signal, busy, training_done, converged, timeout, epoch_count
   );
endinterface

// File: rtl/training_sequencer.sv
// Epoch-level training controller: drives the adam/manhattan update enables, counts epochs
// and ends a run on a convergence streak or on the epoch limit.
module training_sequencer #(
   parameter int unsigned ERR_W        = 34,
   parameter int unsigned EPOCH_W      = 16,
   parameter int unsigned PATIENCE     = 3,
   parameter int unsigned SWITCH_EPOCH = 8
) (
   input  logic                clk,
   input  logic                rst,
   training_sequencer_if.slave bus
);
   localparam int unsigned STREAK_W = $clog2(PATIENCE + 1);
   localparam logic [STREAK_W:0] PAT_X = (STREAK_W + 1)'(PATIENCE);
   localparam logic [EPOCH_W:0]  SW_X  = (EPOCH_W + 1)'(SWITCH_EPOCH);
   localparam logic [1:0] MODE_MANH = 2'b01;
   localparam logic [1:0] MODE_HYB  = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t              state_q;
   logic [1:0]          mode_q;
   logic [EPOCH_W-1:0]  max_q;
   logic [ERR_W-1:0]    thr_q;
   logic [EPOCH_W-1:0]  epoch_q;
   logic [STREAK_W-1:0] streak_q;
   logic                conv_q, tout_q, adam_q, manh_q, busy_q, done_q;

   logic [EPOCH_W-1:0]  epoch_d;
   logic [STREAK_W-1:0] streak_d;
   logic [STREAK_W:0]   streak_p1;
   logic                below, conv_hit, limit_hit;
   logic [1:0]          en_run, en_start;

   function automatic logic [EPOCH_W-1:0] sat_inc(input logic [EPOCH_W-1:0] v);
      return (&v) ? v : v + {{(EPOCH_W-1){1'b0}}, 1'b1};
   endfunction

   // Returns {adam, manhattan}; the reserved mode code behaves as adam.
   function automatic logic [1:0] enables(input logic [1:0] mode, input logic [EPOCH_W-1:0] ep);
      case (mode)
         MODE_MANH: return 2'b01;
         MODE_HYB:  return ({1'b0, ep} < SW_X) ? 2'b10 : 2'b01;
         default:   return 2'b10;
      endcase
   endfunction

   always_comb begin
      epoch_d   = sat_inc(epoch_q);
      below     = (bus.squared_error <= thr_q);
      streak_p1 = {1'b0, streak_q} + {{STREAK_W{1'b0}}, 1'b1};
      streak_d  = below ? streak_p1[STREAK_W-1:0] : '0;
      conv_hit  = below && (streak_p1 >= PAT_X);
      limit_hit = (max_q != '0) && (epoch_d == max_q);
      en_run    = enables(mode_q, epoch_d);
      en_start  = enables(bus.mode_sel, '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         mode_q   <= '0;
         max_q    <= '0;
         thr_q    <= '0;
         epoch_q  <= '0;
         streak_q <= '0;
         conv_q   <= 1'b0;
         tout_q   <= 1'b0;
         adam_q   <= 1'b0;
         manh_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else if (bus.abort) begin
         // Abort wins over start and err_valid; the epoch count is kept for inspection.
         state_q <= S_IDLE;
         conv_q  <= 1'b0;
         tout_q  <= 1'b0;
         adam_q  <= 1'b0;
         manh_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_RUN: begin
               if (bus.err_valid) begin
                  epoch_q  <= epoch_d;
                  streak_q <= streak_d;
                  if (conv_hit || limit_hit) begin
                     state_q <= S_DONE;
                     conv_q  <= conv_hit;
                     tout_q  <= ~conv_hit;
                     adam_q  <= 1'b0;
                     manh_q  <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     adam_q <= en_run[1];
                     manh_q <= en_run[0];
                  end
               end
            end
            default: begin
               if (bus.start) begin
                  state_q  <= S_RUN;
                  mode_q   <= bus.mode_sel;
                  max_q    <= bus.max_epochs;
                  thr_q    <= bus.err_threshold;
                  epoch_q  <= '0;
                  streak_q <= '0;
                  conv_q   <= 1'b0;
                  tout_q   <= 1'b0;
                  adam_q   <= en_start[1];
                  manh_q   <= en_start[0];
                  busy_q   <= 1'b1;
                  done_q   <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.adam_signal      = adam_q;
   assign bus.manhatten_signal = manh_q;
   assign bus.busy             = busy_q;
   assign bus.training_done    = done_q;
   assign bus.converged        = conv_q;
   assign bus.timeout          = tout_q;
   assign bus.epoch_count      = epoch_q;
endmodule

// File: tb/tb_training_sequencer.sv
// Directed bench for training_sequencer: run outcomes are queued when a run is launched and
// compared when the sequencer reports training_done.
module tb_training_sequencer;
   localparam int ERR_W   = 34;
   localparam int EPOCH_W = 16;

   typedef struct packed {
      logic               conv;
      logic               tout;
      logic [EPOCH_W-1:0] ep;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int unsigned errs_038[7] = '{500, 90, 80, 120, 50, 40, 30};

   training_sequencer_if #(.ERR_W(ERR_W), .EPOCH_W(EPOCH_W)) ifa ();
   training_sequencer_if #(.ERR_W(ERR_W), .EPOCH_W(EPOCH_W)) ifb ();

   training_sequencer #(.ERR_W(ERR_W), .EPOCH_W(EPOCH_W), .PATIENCE(3), .SWITCH_EPOCH(8))
      u_dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
   training_sequencer #(.ERR_W(ERR_W), .EPOCH_W(EPOCH_W), .PATIENCE(1), .SWITCH_EPOCH(0))
      u_dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_a(input logic [1:0] mode, input int unsigned thr, input int unsigned maxe);
      ifa.mode_sel      = mode;
      ifa.err_threshold = ERR_W'(thr);
      ifa.max_epochs    = EPOCH_W'(maxe);
      ifa.start         = 1'b1;
      step();
      ifa.start         = 1'b0;
   endtask

   task automatic epoch_a(input int unsigned err);
      ifa.squared_error = ERR_W'(err);
      ifa.err_valid     = 1'b1;
      step();
      ifa.err_valid     = 1'b0;
   endtask

   task automatic sb_compare(input string tag, input logic done, input logic conv, input logic tout,
                             input logic [EPOCH_W-1:0] ep, input logic busy, input logic adam,
                             input logic manh);
      exp_t e;
      check({tag, "_done"}, done, 1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check({tag, "_converged"}, conv, e.conv);
         check({tag, "_timeout"}, tout, e.tout);
         check({tag, "_epochs"}, ep, e.ep);
      end else begin
         check({tag, "_sb_pending"}, sb_q.size(), 1);
      end
      check({tag, "_busy"}, busy, 0);
      check({tag, "_enables"}, {adam, manh}, 2'b00);
   endtask

   task automatic wait_done_a(input string tag, input int budget);
      int n = 0;
      while (!ifa.training_done && n < budget) begin
         step();
         n++;
      end
      sb_compare(tag, ifa.training_done, ifa.converged, ifa.timeout, ifa.epoch_count,
                 ifa.busy, ifa.adam_signal, ifa.manhatten_signal);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      ifa.start = 0; ifa.abort = 0; ifa.mode_sel = 0; ifa.err_valid = 0;
      ifa.squared_error = '0; ifa.err_threshold = '0; ifa.max_epochs = '0;
      ifb.start = 0; ifb.abort = 0; ifb.mode_sel = 0; ifb.err_valid = 0;
      ifb.squared_error = '0; ifb.err_threshold = '0; ifb.max_epochs = '0;
      rst = 1'b1;
      step();
      step();
      check("rst_busy", ifa.busy, 0);
      check("rst_done", ifa.training_done, 0);
      check("rst_enables", {ifa.adam_signal, ifa.manhatten_signal}, 2'b00);
      check("rst_flags", {ifa.converged, ifa.timeout}, 2'b00);
      check("rst_epoch", ifa.epoch_count, 0);
      rst = 1'b0;
      step();

      // Adam run converging after a streak broken once.
      start_a(2'b00, 100, 0);
      sb_q.push_back('{conv: 1'b1, tout: 1'b0, ep: 16'd7});
      check("adam_entry_busy", ifa.busy, 1);
      check("adam_entry_en", {ifa.adam_signal, ifa.manhatten_signal}, 2'b10);
      check("adam_entry_epoch", ifa.epoch_count, 0);
      for (int i = 0; i < 7; i++) begin
         epoch_a(errs_038[i]);
         if (i < 6) begin
            check("adam_run_en", {ifa.busy, ifa.adam_signal, ifa.manhatten_signal}, 3'b110);
            check("adam_run_epoch", ifa.epoch_count, i + 1);
         end
      end
      wait_done_a("adam_conv", 4);
      step();
      step();
      check("adam_done_hold", {ifa.training_done, ifa.converged}, 2'b11);
      check("adam_done_epoch", ifa.epoch_count, 7);

      // Hybrid run started from DONE, handover at epoch 8.
      start_a(2'b10, 100, 0);
      check("hyb_entry_en", {ifa.adam_signal, ifa.manhatten_signal}, 2'b10);
      check("hyb_entry_flags", {ifa.training_done, ifa.converged, ifa.epoch_count}, 0);
      for (int i = 1; i <= 12; i++) begin
         epoch_a(1000);
         check("hyb_en", {ifa.adam_signal, ifa.manhatten_signal}, (i < 8) ? 2'b10 : 2'b01);
      end
      start_a(2'b00, 100, 0);
      check("hyb_start_ignored_en", {ifa.adam_signal, ifa.manhatten_signal}, 2'b01);
      check("hyb_start_ignored_epoch", ifa.epoch_count, 12);
      ifa.abort = 1'b1;
      step();
      ifa.abort = 1'b0;
      check("hyb_abort_state", {ifa.busy, ifa.training_done, ifa.adam_signal, ifa.manhatten_signal}, 0);
      check("hyb_abort_epoch", ifa.epoch_count, 12);

      // Manhattan run ending on the epoch limit.
      start_a(2'b01, 100, 5);
      sb_q.push_back('{conv: 1'b0, tout: 1'b1, ep: 16'd5});
      check("manh_entry_en", {ifa.adam_signal, ifa.manhatten_signal}, 2'b01);
      for (int i = 0; i < 5; i++) epoch_a(200);
      wait_done_a("manh_timeout", 4);
      epoch_a(50);
      check("done_ignores_err_epoch", ifa.epoch_count, 5);
      check("done_ignores_err_flags", {ifa.training_done, ifa.converged, ifa.timeout}, 3'b101);

      // Convergence and epoch limit on the same err_valid; error equal to threshold counts.
      start_a(2'b00, 100, 3);
      sb_q.push_back('{conv: 1'b1, tout: 1'b0, ep: 16'd3});
      for (int i = 0; i < 3; i++) epoch_a(100);
      wait_done_a("simul_conv", 4);

      // Abort together with start and err_valid at epoch 3.
      start_a(2'b00, 100, 0);
      for (int i = 0; i < 3; i++) epoch_a(500);
      ifa.abort = 1'b1; ifa.start = 1'b1; ifa.err_valid = 1'b1; ifa.squared_error = '0;
      step();
      ifa.abort = 1'b0; ifa.start = 1'b0; ifa.err_valid = 1'b0;
      check("abort_prio_state", {ifa.busy, ifa.training_done, ifa.adam_signal, ifa.manhatten_signal}, 0);
      check("abort_prio_epoch", ifa.epoch_count, 3);
      step();
      check("abort_prio_stays_idle", ifa.busy, 0);

      // Asynchronous reset mid-run.
      start_a(2'b00, 100, 0);
      epoch_a(500);
      epoch_a(500);
      #2 rst = 1'b1;
      #1;
      check("async_rst_outputs", {ifa.busy, ifa.adam_signal, ifa.manhatten_signal, ifa.training_done}, 0);
      check("async_rst_epoch", ifa.epoch_count, 0);
      #2 rst = 1'b0;
      step();
      step();
      check("post_rst_idle", {ifa.busy, ifa.training_done}, 2'b00);
      start_a(2'b00, 100, 0);
      check("post_rst_start", {ifa.busy, ifa.adam_signal, ifa.epoch_count}, {2'b11, 16'd0});
      epoch_a(500);
      check("post_rst_epoch", ifa.epoch_count, 1);
      ifa.abort = 1'b1;
      step();
      ifa.abort = 1'b0;

      // PATIENCE=1, SWITCH_EPOCH=0 instance: zero error at threshold 0 with a one-epoch limit.
      ifb.mode_sel = 2'b10; ifb.err_threshold = '0; ifb.max_epochs = 16'd1; ifb.start = 1'b1;
      step();
      ifb.start = 1'b0;
      sb_q.push_back('{conv: 1'b1, tout: 1'b0, ep: 16'd1});
      check("p1_entry_en", {ifb.busy, ifb.adam_signal, ifb.manhatten_signal}, 3'b101);
      ifb.squared_error = '0; ifb.err_valid = 1'b1;
      step();
      ifb.err_valid = 1'b0;
      sb_compare("p1_conv", ifb.training_done, ifb.converged, ifb.timeout, ifb.epoch_count,
                 ifb.busy, ifb.adam_signal, ifb.manhatten_signal);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/training_sequencer.md
TRAINING_SEQUENCER -- requirements
Module: training_sequencer

Interface
REQ-001 SHALL have parameter ERR_W, default 34, width of squared-error and threshold.
REQ-002 SHALL have parameter EPOCH_W, default 16, width of epoch counter and epoch limit.
REQ-003 SHALL have parameter PATIENCE, default 3, consecutive below-threshold epochs required for convergence (>=1).
REQ-004 SHALL have parameter SWITCH_EPOCH, default 8, epoch at which hybrid mode hands over from adam to manhattan.
REQ-005 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start  in  1  single-cycle request to begin a training run.
REQ-008 SHALL have port abort  in  1  cancel current run.
REQ-009 SHALL have port mode_sel  in  2  00 adam, 01 manhattan, 10 hybrid, 11 reserved (treated as adam).
REQ-010 SHALL have port err_valid  in  1  one pulse per completed epoch, qualifies squared_error.
REQ-011 SHALL have port squared_error  in  ERR_W  epoch squared error, unsigned.
REQ-012 SHALL have port err_threshold  in  ERR_W  convergence threshold, unsigned.
REQ-013 SHALL have port max_epochs  in  EPOCH_W  epoch limit; 0 = unlimited.
REQ-014 SHALL have port adam_signal  out  1  enables adam update block.
REQ-015 SHALL have port manhatten_signal  out  1  enables manhattan update block.
REQ-016 SHALL have port busy  out  1  high while in RUN.
REQ-017 SHALL have port training_done  out  1  high while in DONE.
REQ-018 SHALL have port converged  out  1  run ended by convergence; valid with training_done.
REQ-019 SHALL have port timeout  out  1  run ended by epoch limit; valid with training_done.
REQ-020 SHALL have port epoch_count  out  EPOCH_W  epochs completed in current/last run.

Function
REQ-021 SHALL implement states IDLE, RUN, DONE; all outputs registered.
REQ-022 IDLE + start SHALL move to RUN next edge: latch mode_sel, max_epochs, err_threshold; clear epoch_count, streak counter, converged, timeout.
REQ-023 start SHALL be ignored in RUN; in DONE start SHALL begin a new run exactly as from IDLE.
REQ-024 In RUN, adam_signal/manhatten_signal SHALL follow the latched mode: adam -> 1/0, manhattan -> 0/1, hybrid -> 1/0 while epoch_count < SWITCH_EPOCH else 0/1; never both high.
REQ-025 Enables SHALL assert on the same edge RUN is entered and deassert on the edge RUN is left.
REQ-026 Each err_valid in RUN SHALL increment epoch_count by 1 (saturating at all-ones); err_valid outside RUN SHALL be ignored.
REQ-027 Streak counter SHALL increment when squared_error <= latched threshold, else clear to 0, on each err_valid.
REQ-028 When the streak reaches PATIENCE, next state SHALL be DONE with converged=1, timeout=0.
REQ-029 When latched max_epochs != 0 and the incremented epoch_count equals it, next state SHALL be DONE with timeout=1, unless REQ-028 also fires.
REQ-030 Simultaneous convergence and epoch-limit on the same err_valid SHALL report converged=1, timeout=0.
REQ-031 squared_error == 0 SHALL count as below threshold (including threshold 0).
REQ-032 abort in RUN or DONE SHALL return to IDLE next edge, clearing enables, busy, training_done, converged, timeout; epoch_count retained.
REQ-033 abort SHALL take priority over start and err_valid in the same cycle.
REQ-034 Hybrid handover SHALL occur on the edge where epoch_count becomes SWITCH_EPOCH; SWITCH_EPOCH=0 yields manhattan from entry.
REQ-035 In DONE, training_done, converged, timeout, epoch_count SHALL hold until start, abort or reset.

Reset
REQ-036 rst SHALL immediately force IDLE, all outputs 0, epoch_count 0, streak 0, latched configuration 0.
REQ-037 rst asserted mid-run SHALL abandon the run; no training_done pulse on release.

Verification
REQ-038 Adam, PATIENCE=3, threshold 100, errors 500,90,80,120,50,40,30 -> done after 7th err_valid, converged=1, epoch_count=7, adam_signal high throughout RUN then 0.
REQ-039 Hybrid, SWITCH_EPOCH=8, errors all 1000 -> adam_signal high epochs 0-7, manhatten_signal from epoch_count=8, never both high.
REQ-040 max_epochs=5, errors above threshold -> DONE after 5th err_valid, timeout=1, converged=0, epoch_count=5.
REQ-041 PATIENCE=1, max_epochs=1, first error 0 -> converged=1, timeout=0.
REQ-042 abort during RUN at epoch 3 with start same cycle -> IDLE, enables 0, training_done 0, epoch_count 3.
REQ-043 rst pulsed mid-run -> all outputs 0 asynchronously; subsequent start begins clean run from epoch 0.
